dcache_assoc_sram: RTL and testbench
====================================

# dcache_assoc_sram

Parametrised N-way set-associative data-cache storage array with true-LRU replacement. It succeeds the fixed 2-way/16-set dcache SRAM and sits between the dcache controller FSM and the data-memory interface. It resolves hit/miss, selects victims, tracks valid and dirty state, and returns the evicted line for write-back. All operations complete with a fixed one-cycle registered response.

## Interface
- NUM_SETS, 16, number of sets, power of two ≥ 2
- NUM_WAYS, 2, associativity, power of two, 2..8
- TAG_W, 23, stored tag width
- LINE_W, 256, line width in bits (32 B default)
- IDX_W, $clog2(NUM_SETS), derived, not overridable
- clk_i  in  1  single clock; all state changes on its rising edge
- rst_i  in  1  synchronous, active-low reset
- req_i  in  1  request strobe; one operation per cycle when high
- op_i  in  2  operation: READ=0, WRITE=1, REFILL=2, INVAL=3
- addr_i  in  IDX_W  set index
- tag_i  in  TAG_W  lookup tag
- data_i  in  LINE_W  line data for WRITE/REFILL
- dirty_i  in  1  dirty value installed by REFILL
- rsp_valid_o  out  1  response valid, one cycle after req_i
- hit_o  out  1  lookup hit
- way_o  out  $clog2(NUM_WAYS)  hit way, or victim way on miss
- tag_o  out  TAG_W+2  {valid, dirty, tag} of way_o before this op's update
- data_o  out  LINE_W  line of way_o before this op's update

## Operation
- Hit: some way in set addr_i has valid=1 and stored tag == tag_i. At most one way can hit.
- Victim on miss: lowest-index invalid way. If all ways are valid, the way with age NUM_WAYS-1.
- READ: no array change. On hit, the hit way becomes MRU.
- WRITE: on hit, overwrite data, set dirty=1, make MRU. On miss, no change (controller must REFILL first).
- REFILL: on hit, overwrite the hit way; this prevents duplicate tags. On miss, overwrite the victim. Installed way gets valid=1, dirty=dirty_i, tag=tag_i, data=data_i, and becomes MRU. The response reports the evicted line so the controller can write back when tag_o valid and dirty are both 1.
- INVAL: on hit, clear valid and dirty, and make the way LRU. On miss, no change.
- LRU: per-set age vector, one $clog2(NUM_WAYS)-bit age per way, ages always a permutation of 0..NUM_WAYS-1.
  - Make MRU(w): ages below old age(w) increment; age(w) becomes 0.
  - Make LRU(w): ages above old age(w) decrement; age(w) becomes NUM_WAYS-1.
- Reset (rst_i=0 at an edge):
  - All valid, dirty and tag bits clear; age(way k)=k.
  - Data array is not reset.
  - rsp_valid_o=0, hit_o=0, way_o=0, tag_o=0, data_o=0.
  - A request in flight during reset is dropped; no response is issued.
- req_i=0: no state change; rsp_valid_o=0 next cycle; other outputs hold their last value.

## Timing
- Lookup is combinational from the arrays. All outputs are registered, so response latency is exactly 1 cycle.
- Full throughput: a new request is accepted every cycle with no stall and no ready signal.
- Back-to-back same set: the request at cycle n+1 observes all array and LRU updates from cycle n (read-after-write through the register arrays, no bypass hazard).
- tag_o/data_o show pre-update contents, sampled in the same cycle the update is written.

## Structure
- Shared package cache_pkg holds:
  - op_e encoding (READ/WRITE/REFILL/INVAL);
  - tag_o field offsets VALID_BIT=TAG_W+1, DIRTY_BIT=TAG_W;
  - defaults for NUM_SETS, NUM_WAYS, TAG_W, LINE_W.
- Sub-module cache_lru_ctrl (parametrised by NUM_WAYS):
  - inputs: one set's age vector, target way, mode {MRU, LRU}, enable;
  - output: next age vector (combinational).
  - Instantiated once, operating on the addressed set.
- Top level holds the tag/valid/dirty/data/age arrays, hit compare, victim select and response registers.

## Test plan
- Reset, then READ set 3 tag 0x1 → next cycle rsp_valid_o=1, hit_o=0, way_o=0, tag_o=0.
- REFILL set 3, tag 0x1, data 0xA…A, dirty_i=0, then READ tag 0x1 → hit_o=1, way_o=0, data_o=0xA…A, tag_o={1,0,0x1}.
- NUM_WAYS=2, set 5: REFILL tags 0x10 then 0x20, READ 0x10, then REFILL 0x30 → way_o=1 (the 0x20 way) and tag_o reports 0x20. A subsequent READ of 0x20 misses.
- WRITE hit on tag 0x10 with 0x55…, then REFILL a new tag that evicts it → tag_o={1,1,0x10}, data_o=0x55….
- Back-to-back REFILL then READ of the same set/tag on consecutive cycles → second response hit_o=1 with the new data.
- INVAL a hit way, then REFILL a new tag into the full set → the invalidated way is chosen; rst_i=0 asserted mid-stream → all responses suppressed and all ways invalid afterwards.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative dcache storage array and its LRU helper.
package cache_pkg;

  localparam int DEF_NUM_SETS = 16;
  localparam int DEF_NUM_WAYS = 2;
  localparam int DEF_TAG_W    = 23;
  localparam int DEF_LINE_W   = 256;

  // Field positions inside tag_o = {valid, dirty, tag} for the default tag width
  localparam int VALID_BIT = DEF_TAG_W + 1;
  localparam int DIRTY_BIT = DEF_TAG_W;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_REFILL = 2'd2,
    OP_INVAL  = 2'd3
  } op_e;

  typedef enum logic {
    LRU_MODE_MRU = 1'b0,
    LRU_MODE_LRU = 1'b1
  } lru_mode_e;

endpackage

// File: rtl/cache_lru_ctrl.sv
// Next-state computation for one set's true-LRU age vector (age 0 = MRU).
module cache_lru_ctrl
  import cache_pkg::*;
#(
  parameter  int NUM_WAYS = DEF_NUM_WAYS,
  localparam int AGE_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS*AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0]          way_i,
  input  logic                      mode_i,
  input  logic                      en_i,
  output logic [NUM_WAYS*AGE_W-1:0] age_o
);

  logic [AGE_W-1:0] old_age;
  logic [AGE_W-1:0] cur_age;

  always_comb begin
    age_o   = age_i;
    old_age = age_i[way_i*AGE_W +: AGE_W];
    cur_age = '0;
    if (en_i) begin
      for (int unsigned k = 0; k < NUM_WAYS; k++) begin
        cur_age = age_i[k*AGE_W +: AGE_W];
        if (AGE_W'(k) == way_i) begin
          age_o[k*AGE_W +: AGE_W] = (mode_i == LRU_MODE_LRU) ? AGE_W'(NUM_WAYS - 1) : '0;
        end else if (mode_i == LRU_MODE_MRU && cur_age < old_age) begin
          age_o[k*AGE_W +: AGE_W] = cur_age + 1'b1;
        end else if (mode_i == LRU_MODE_LRU && cur_age > old_age) begin
          age_o[k*AGE_W +: AGE_W] = cur_age - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dcache_assoc_sram.sv
// N-way set-associative dcache storage: hit/miss, victim choice, valid/dirty
// tracking and registered one-cycle response reporting the pre-update line.
module dcache_assoc_sram
  import cache_pkg::*;
#(
  parameter  int NUM_SETS = DEF_NUM_SETS,
  parameter  int NUM_WAYS = DEF_NUM_WAYS,
  parameter  int TAG_W    = DEF_TAG_W,
  parameter  int LINE_W   = DEF_LINE_W,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  output logic              rsp_valid_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o,
  output logic [TAG_W+1:0]  tag_o,
  output logic [LINE_W-1:0] data_o
);

  logic [TAG_W-1:0]          tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]         data_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]       valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]       dirty_q [NUM_SETS];
  logic [NUM_WAYS*WAY_W-1:0] age_q   [NUM_SETS];

  op_e                       op;
  logic [NUM_WAYS-1:0]       hit_vec;
  logic                      hit;
  logic [WAY_W-1:0]          hit_way;
  logic [WAY_W-1:0]          victim_way;
  logic                      found_invalid;
  logic [WAY_W-1:0]          sel_way;
  logic                      lru_en;
  logic                      lru_mode;
  logic [NUM_WAYS*WAY_W-1:0] age_nxt;

  assign op = op_e'(op_i);

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned k = 0; k < NUM_WAYS; k++) begin
      hit_vec[k] = valid_q[addr_i][k] && (tag_q[addr_i][k] == tag_i);
      if (hit_vec[k]) hit_way = WAY_W'(k);
    end
  end

  assign hit = |hit_vec;

  // Lowest invalid way wins; only a full set falls back to the oldest way
  always_comb begin
    victim_way    = '0;
    found_invalid = 1'b0;
    for (int unsigned k = 0; k < NUM_WAYS; k++) begin
      if (!valid_q[addr_i][k] && !found_invalid) begin
        victim_way    = WAY_W'(k);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int unsigned k = 0; k < NUM_WAYS; k++) begin
        if (age_q[addr_i][k*WAY_W +: WAY_W] == WAY_W'(NUM_WAYS - 1)) victim_way = WAY_W'(k);
      end
    end
  end

  assign sel_way = hit ? hit_way : victim_way;

  always_comb begin
    lru_en   = 1'b0;
    lru_mode = LRU_MODE_MRU;
    if (req_i) begin
      unique case (op)
        OP_READ, OP_WRITE: lru_en = hit;
        OP_REFILL:         lru_en = 1'b1;
        OP_INVAL: begin
          lru_en   = hit;
          lru_mode = LRU_MODE_LRU;
        end
        default: lru_en = 1'b0;
      endcase
    end
  end

  cache_lru_ctrl #(
    .NUM_WAYS(NUM_WAYS)
  ) u_lru (
    .age_i  (age_q[addr_i]),
    .way_i  (sel_way),
    .mode_i (lru_mode),
    .en_i   (lru_en),
    .age_o  (age_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int unsigned k = 0; k < NUM_WAYS; k++) begin
          tag_q[s][k]                  <= '0;
          age_q[s][k*WAY_W +: WAY_W]   <= WAY_W'(k);
        end
      end
      rsp_valid_o <= 1'b0;
      hit_o       <= 1'b0;
      way_o       <= '0;
      tag_o       <= '0;
      data_o      <= '0;
    end else begin
      rsp_valid_o <= req_i;
      if (req_i) begin
        hit_o         <= hit;
        way_o         <= sel_way;
        tag_o         <= {valid_q[addr_i][sel_way], dirty_q[addr_i][sel_way], tag_q[addr_i][sel_way]};
        data_o        <= data_q[addr_i][sel_way];
        age_q[addr_i] <= age_nxt;
        unique case (op)
          OP_WRITE: if (hit) dirty_q[addr_i][sel_way] <= 1'b1;
          OP_REFILL: begin
            valid_q[addr_i][sel_way] <= 1'b1;
            dirty_q[addr_i][sel_way] <= dirty_i;
            tag_q[addr_i][sel_way]   <= tag_i;
          end
          OP_INVAL: if (hit) begin
            valid_q[addr_i][sel_way] <= 1'b0;
            dirty_q[addr_i][sel_way] <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Line storage has no reset; writes are still blocked while reset is held
  always_ff @(posedge clk_i) begin
    if (rst_i && req_i && ((op == OP_WRITE && hit) || op == OP_REFILL)) begin
      data_q[addr_i][sel_way] <= data_i;
    end
  end

endmodule

// File: tb/tb_dcache_assoc_sram.sv
// Bench for dcache_assoc_sram: directed vector table, mid-stream reset and random ops vs. a timestamp LRU model.
module tb_dcache_assoc_sram;
  import cache_pkg::*;

  localparam int NS = 16;
  localparam int NW = 2;
  localparam int TW = 23;
  localparam int LW = 256;
  localparam int IW = 4;
  localparam int WW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [1:0]    op;
  logic [IW-1:0] addr;
  logic [TW-1:0] tag;
  logic [LW-1:0] data;
  logic          dirty;
  logic          rsp_valid;
  logic          hit;
  logic [WW-1:0] way;
  logic [TW+1:0] tag_out;
  logic [LW-1:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  dcache_assoc_sram #(
    .NUM_SETS(NS),
    .NUM_WAYS(NW),
    .TAG_W(TW),
    .LINE_W(LW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .op_i        (op),
    .addr_i      (addr),
    .tag_i       (tag),
    .data_i      (data),
    .dirty_i     (dirty),
    .rsp_valid_o (rsp_valid),
    .hit_o       (hit),
    .way_o       (way),
    .tag_o       (tag_out),
    .data_o      (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    int            set;
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
    logic          dirty;
    logic          ehit;
    int            eway;
    logic [TW+1:0] etag;
    bit            cdata;
    logic [LW-1:0] edata;
  } vec_t;

  vec_t tbl[$];

  // Reference model: recency is a per-way timestamp; larger means more recently used
  bit            m_valid [NS][NW];
  bit            m_dirty [NS][NW];
  bit [TW-1:0]   m_tag   [NS][NW];
  bit [LW-1:0]   m_data  [NS][NW];
  bit            m_known [NS][NW];
  longint        m_ts    [NS][NW];
  longint        mru_ctr;
  longint        lru_ctr;

  bit            e_hit;
  int            e_way;
  bit [TW+1:0]   e_tag;
  bit [LW-1:0]   e_data;
  bit            e_known;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < NW; k++) begin
        m_valid[s][k] = 1'b0;
        m_dirty[s][k] = 1'b0;
        m_tag[s][k]   = '0;
        m_ts[s][k]    = -longint'(k);
      end
    end
    mru_ctr = 0;
    lru_ctr = -longint'(NW);
  endtask

  task automatic model_req(input logic [1:0] mop, input int s, input logic [TW-1:0] t,
                           input logic [LW-1:0] d, input logic dy);
    int hw;
    int w;
    hw = -1;
    for (int k = 0; k < NW; k++) if (m_valid[s][k] && m_tag[s][k] == t) hw = k;
    if (hw >= 0) w = hw;
    else begin
      w = -1;
      for (int k = 0; k < NW; k++) if (!m_valid[s][k] && w < 0) w = k;
      if (w < 0) begin
        w = 0;
        for (int k = 1; k < NW; k++) if (m_ts[s][k] < m_ts[s][w]) w = k;
      end
    end
    e_hit   = (hw >= 0);
    e_way   = w;
    e_tag   = {m_valid[s][w], m_dirty[s][w], m_tag[s][w]};
    e_data  = m_data[s][w];
    e_known = m_known[s][w];
    if (mop == OP_READ && e_hit) begin
      mru_ctr++; m_ts[s][w] = mru_ctr;
    end else if (mop == OP_WRITE && e_hit) begin
      m_data[s][w] = d; m_known[s][w] = 1'b1; m_dirty[s][w] = 1'b1;
      mru_ctr++; m_ts[s][w] = mru_ctr;
    end else if (mop == OP_REFILL) begin
      m_valid[s][w] = 1'b1; m_dirty[s][w] = dy; m_tag[s][w] = t;
      m_data[s][w] = d; m_known[s][w] = 1'b1;
      mru_ctr++; m_ts[s][w] = mru_ctr;
    end else if (mop == OP_INVAL && e_hit) begin
      m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
      lru_ctr--; m_ts[s][w] = lru_ctr;
    end
  endtask

  task automatic drive(input logic [1:0] dop, input int s, input logic [TW-1:0] t,
                       input logic [LW-1:0] d, input logic dy);
    @(negedge clk);
    req = 1'b1; op = dop; addr = s[IW-1:0]; tag = t; data = d; dirty = dy;
    model_req(dop, s, t, d, dy);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string pfx);
    chk({pfx, "_valid"}, rsp_valid, 1'b1);
    chk({pfx, "_hit"}, hit, e_hit);
    chk({pfx, "_way"}, way, e_way[WW-1:0]);
    chk({pfx, "_tag"}, tag_out, e_tag);
    if (e_known) chk({pfx, "_data"}, data_out, e_data);
  endtask

  function automatic vec_t mk(input logic [1:0] vop, input int s, input logic [TW-1:0] t,
                              input logic [LW-1:0] d, input logic dy, input logic eh, input int ew,
                              input logic ev, input logic ed, input logic [TW-1:0] et,
                              input bit cd, input logic [LW-1:0] edt);
    vec_t v;
    v.op = vop; v.set = s; v.tag = t; v.data = d; v.dirty = dy;
    v.ehit = eh; v.eway = ew; v.etag = {ev, ed, et}; v.cdata = cd; v.edata = edt;
    return v;
  endfunction

  initial begin
    logic [LW-1:0] aa, p55, d1, d2, d3, d4, d5, rnd;
    logic [1:0]    rop;
    int            rs;
    aa  = {64{4'hA}};
    p55 = {32{8'h55}};
    d1  = {8{32'h1111_0010}};
    d2  = {8{32'h2222_0020}};
    d3  = {8{32'h3333_0030}};
    d4  = {8{32'h4444_0040}};
    d5  = {8{32'h5555_0050}};

    rst = 1'b0; req = 1'b0; op = '0; addr = '0; tag = '0; data = '0; dirty = 1'b0;
    model_reset();
    for (int s = 0; s < NS; s++) for (int k = 0; k < NW; k++) m_known[s][k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_hit", hit, 1'b0);
    chk("reset_way", way, '0);
    chk("reset_tag", tag_out, '0);
    chk("reset_data", data_out, '0);
    @(negedge clk);
    rst = 1'b1;

    //            op         set tag    data dy  hit way v  d  tag    cd  data
    tbl.push_back(mk(OP_READ,   3, 23'h1,  '0,  0,  0,  0, 0, 0, 23'h0,  0, '0));
    tbl.push_back(mk(OP_REFILL, 3, 23'h1,  aa,  0,  0,  0, 0, 0, 23'h0,  0, '0));
    tbl.push_back(mk(OP_READ,   3, 23'h1,  '0,  0,  1,  0, 1, 0, 23'h1,  1, aa));
    tbl.push_back(mk(OP_REFILL, 5, 23'h10, d1,  0,  0,  0, 0, 0, 23'h0,  0, '0));
    tbl.push_back(mk(OP_REFILL, 5, 23'h20, d2,  0,  0,  1, 0, 0, 23'h0,  0, '0));
    tbl.push_back(mk(OP_READ,   5, 23'h10, '0,  0,  1,  0, 1, 0, 23'h10, 1, d1));
    tbl.push_back(mk(OP_WRITE,  5, 23'h10, p55, 0,  1,  0, 1, 0, 23'h10, 1, d1));
    tbl.push_back(mk(OP_REFILL, 5, 23'h30, d3,  0,  0,  1, 1, 0, 23'h20, 1, d2));
    tbl.push_back(mk(OP_READ,   5, 23'h20, '0,  0,  0,  0, 1, 1, 23'h10, 1, p55));
    tbl.push_back(mk(OP_REFILL, 5, 23'h40, d4,  1,  0,  0, 1, 1, 23'h10, 1, p55));
    tbl.push_back(mk(OP_READ,   5, 23'h40, '0,  0,  1,  0, 1, 1, 23'h40, 1, d4));
    tbl.push_back(mk(OP_INVAL,  5, 23'h30, '0,  0,  1,  1, 1, 0, 23'h30, 1, d3));
    tbl.push_back(mk(OP_REFILL, 5, 23'h50, d5,  0,  0,  1, 0, 0, 23'h30, 1, d3));
    tbl.push_back(mk(OP_READ,   5, 23'h50, '0,  0,  1,  1, 1, 0, 23'h50, 1, d5));
    tbl.push_back(mk(OP_WRITE,  7, 23'h9,  p55, 0,  0,  0, 0, 0, 23'h0,  0, '0));
    tbl.push_back(mk(OP_READ,   7, 23'h9,  '0,  0,  0,  0, 0, 0, 23'h0,  0, '0));

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].set, tbl[i].tag, tbl[i].data, tbl[i].dirty);
      chk($sformatf("vec%0d_valid", i), rsp_valid, 1'b1);
      chk($sformatf("vec%0d_hit", i), hit, tbl[i].ehit);
      chk($sformatf("vec%0d_way", i), way, tbl[i].eway[WW-1:0]);
      chk($sformatf("vec%0d_tag", i), tag_out, tbl[i].etag);
      if (tbl[i].cdata) chk($sformatf("vec%0d_data", i), data_out, tbl[i].edata);
    end

    // Idle cycle: no response, outputs hold
    @(negedge clk);
    req = 1'b0; op = OP_REFILL; addr = 4'd7; tag = 23'h9;
    @(posedge clk);
    #1;
    chk("idle_valid", rsp_valid, 1'b0);
    chk("idle_hold_hit", hit, 1'b0);
    chk("idle_hold_tag", tag_out, '0);
    drive(OP_READ, 7, 23'h9, '0, 1'b0);
    chk_model("idle_noupd");

    // Reset asserted with a request in flight
    @(negedge clk);
    rst = 1'b0; req = 1'b1; op = OP_REFILL; addr = 4'd2; tag = 23'h77; data = d1; dirty = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_hit", hit, 1'b0);
    chk("midrst_way", way, '0);
    chk("midrst_tag", tag_out, '0);
    chk("midrst_data", data_out, '0);
    @(posedge clk);
    #1;
    chk("midrst_valid2", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    model_reset();
    drive(OP_READ, 3, 23'h1, '0, 1'b0);
    chk_model("post_rst_s3");
    chk("post_rst_s3_miss", hit, 1'b0);
    drive(OP_READ, 5, 23'h40, '0, 1'b0);
    chk_model("post_rst_s5");
    drive(OP_READ, 5, 23'h50, '0, 1'b0);
    chk_model("post_rst_s5b");
    drive(OP_READ, 2, 23'h77, '0, 1'b0);
    chk_model("post_rst_s2");

    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < LW / 32; c++) rnd[c*32 +: 32] = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        req = 1'b0; op = 2'($urandom_range(0, 3)); addr = 4'($urandom_range(0, 3));
        tag = 23'($urandom_range(0, 5)); data = rnd;
        @(posedge clk);
        #1;
        chk("rnd_idle_valid", rsp_valid, 1'b0);
        chk("rnd_idle_hit", hit, e_hit);
        chk("rnd_idle_way", way, e_way[WW-1:0]);
        chk("rnd_idle_tag", tag_out, e_tag);
        if (e_known) chk("rnd_idle_data", data_out, e_data);
      end else begin
        rop = 2'($urandom_range(0, 3));
        rs  = $urandom_range(0, 3);
        drive(rop, rs, 23'($urandom_range(0, 5)), rnd, 1'($urandom_range(0, 1)));
        chk_model($sformatf("rnd%0d", i));
      end
    end

    @(negedge clk);
    req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
